la_arbmux2: RTL

LA_ARBMUX2 -- requirements
Module: la_arbmux2

---
 rtl/la_arbmux2.sv | 114 +++++++++++
 1 files changed

// File: rtl/la_arbmux2.sv
// Two-input packet arbiter/mux with a single registered output stage and per-packet grant lock.
// Define LA_ARBMUX2_FIXED_PRIO_EN to make port 0 win every idle tie instead of round-robin.
module la_arbmux2 #(
  parameter int DW   = 8,
  parameter     PROP = "DEFAULT"
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          in0_valid,
  input  logic [DW-1:0] in0_data,
  input  logic          in0_last,
  output logic          in0_ready,
  input  logic          in1_valid,
  input  logic [DW-1:0] in1_data,
  input  logic          in1_last,
  output logic          in1_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          out_sel,
  input  logic          out_ready
);

  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

  state_t state, state_nxt;
  logic   gnt0, gnt1;
  logic   load;
  logic   acc0, acc1;
  logic   tie_sel;

  // PROP is informational only.
  if (PROP == "") begin : g_prop_empty
  end

`ifdef LA_ARBMUX2_FIXED_PRIO_EN
  assign tie_sel = 1'b0;
`else
  logic rr;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      rr <= 1'b0;
    end else if (acc0 && in0_last) begin
      rr <= 1'b1;
    end else if (acc1 && in1_last) begin
      rr <= 1'b0;
    end
  end

  assign tie_sel = rr;
`endif

  assign load      = ~out_valid | out_ready;
  assign in0_ready = load & gnt0;
  assign in1_ready = load & gnt1;
  assign acc0      = in0_valid & in0_ready;
  assign acc1      = in1_valid & in1_ready;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    case (state)
      LOCK0:   gnt0 = 1'b1;
      LOCK1:   gnt1 = 1'b1;
      default: begin
        if (in0_valid && in1_valid) begin
          gnt0 = ~tie_sel;
          gnt1 = tie_sel;
        end else begin
          gnt0 = in0_valid;
          gnt1 = in1_valid;
        end
      end
    endcase
    // The lock follows the accepted beat: held until the last beat of the packet.
    if (acc0) begin
      state_nxt = in0_last ? IDLE : LOCK0;
    end else if (acc1) begin
      state_nxt = in1_last ? IDLE : LOCK1;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_sel   <= 1'b0;
    end else if (acc0) begin
      out_valid <= 1'b1;
      out_data  <= in0_data;
      out_last  <= in0_last;
      out_sel   <= 1'b0;
    end else if (acc1) begin
      out_valid <= 1'b1;
      out_data  <= in1_data;
      out_last  <= in1_last;
      out_sel   <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
